// File: rtl/imem_dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_dmem_port_arbiter_if
//  Description : Bundles the fetch channel, the load/store channel and the
//                unified single-ported memory bus seen by the arbiter.
//                slave  = arbiter side, master = datapath/memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction-fetch channel
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    // Load/store channel
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    // Unified memory bus
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter status for PC hold logic
    logic          busy;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_dmem_port_arbiter
//  Description : Shares one single-ported unified memory between the fetch
//                and load/store paths. Fixed data-over-fetch priority, one
//                non-pipelined access at a time sequenced by a fixed-latency
//                counter: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP.
//                Optional anti-starvation (macro ARB_ANTISTARVE_EN) forces a
//                fetch grant after STARVE_MAX consecutive data grants while
//                fetch is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  wire                     clk,
    input  wire                     rst,    // asynchronous, active-low
    imem_dmem_port_arbiter_if.slave bus
);

    localparam int CW = 4;  // holds MEM_LAT-1 for MEM_LAT up to 15

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1) begin : g_bad_param
            $error("imem_dmem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX >= 1");
        end
    endgenerate

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_owner_d;   // 1 = data channel owns the transaction
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_start;
    logic          w_pick_d;

    assign w_start = bus.d_req | bus.i_req;

`ifdef ARB_ANTISTARVE_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0] r_scnt;
    logic           w_force_i;

    assign w_force_i = bus.i_req & bus.d_req & (r_scnt == SCW'(STARVE_MAX));
    assign w_pick_d  = bus.d_req & ~w_force_i;

    // Count consecutive data grants that overtook a waiting fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (!bus.i_req) begin
                r_scnt <= '0;
            end else if (w_start && !w_pick_d) begin
                r_scnt <= '0;
            end else if (w_start && w_pick_d && (r_scnt != SCW'(STARVE_MAX))) begin
                r_scnt <= r_scnt + SCW'(1);
            end
        end
    end
`else
    assign w_pick_d = bus.d_req;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, latency counter and per-channel response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_owner_d <= w_pick_d;
                        r_we      <= w_pick_d & bus.d_we;
                        r_addr    <= w_pick_d ? bus.d_addr : bus.i_addr;
                        r_wdata   <= w_pick_d ? bus.d_wdata : '0;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= CW'(MEM_LAT - 1);
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_owner_d) begin
                            r_d_rdata <= r_we ? '0 : bus.mem_rdata;
                        end else begin
                            r_i_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and Moore-decoded outputs
    always_comb begin
        w_state_nxt   = r_state;
        bus.i_gnt     = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.i_rdata   = r_i_rdata;
        bus.d_rdata   = r_d_rdata;
        bus.busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                bus.mem_en  = 1'b1;
                bus.mem_we  = r_we;
                bus.i_gnt   = ~r_owner_d;
                bus.d_gnt   = r_owner_d;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                bus.i_rvalid = ~r_owner_d;
                bus.d_rvalid = r_owner_d;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_dmem_port_arbiter
//  Description : Self-checking bench for imem_dmem_port_arbiter. A
//                transaction-level model predicts every output each cycle;
//                directed scenarios add hand-computed timing/data checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    imem_dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    imem_dmem_port_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory contents as a pure function of address
    function automatic logic [31:0] memfunc(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h0050_0093;
            32'h0000_0014: return 32'h00A0_0113;
            32'h0000_0040: return 32'hCAFE_0040;
            32'h0000_0200: return 32'h0000_1234;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: data is valid only in the cycle LAT cycles after mem_en
    logic [LAT-1:0] en_p = '0;
    logic [31:0]    ad_p [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            en_p[k] <= en_p[k-1];
            ad_p[k] <= ad_p[k-1];
        end
        en_p[0] <= bus.mem_en;
        ad_p[0] <= bus.mem_addr;
    end
    assign bus.mem_rdata = en_p[LAT-1] ? memfunc(ad_p[LAT-1]) : (32'hBADB_AD00 | 32'(cyc[7:0]));

    // Transaction-level model: one active transaction with ACCESS cycle m_t
    logic        m_act;
    int          m_t;
    logic        m_d;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
    int          m_scnt;
`ifdef ARB_ANTISTARVE_EN
    wire m_force = (m_scnt == SMAX);
`else
    wire m_force = 1'b0;
`endif
    wire m_take_i = bus.i_req && (!bus.d_req || m_force);

    // Model update on each clock edge / asynchronous reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act <= 1'b0; m_t <= 0; m_d <= 1'b0; m_we <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_irdata <= '0; m_drdata <= '0;
            m_scnt <= 0;
        end else if (!m_act) begin
            if (bus.d_req || bus.i_req) begin
                m_act   <= 1'b1;
                m_t     <= cyc + 1;
                m_d     <= !m_take_i;
                m_we    <= !m_take_i && bus.d_we;
                m_addr  <= m_take_i ? bus.i_addr : bus.d_addr;
                m_wdata <= bus.d_wdata;
            end
            if (!bus.i_req || m_take_i) m_scnt <= 0;
            else if (bus.d_req && m_scnt < SMAX) m_scnt <= m_scnt + 1;
        end else begin
            if (cyc == m_t + LAT) begin
                if (m_d) m_drdata <= m_we ? 32'h0 : memfunc(m_addr);
                else     m_irdata <= memfunc(m_addr);
            end
            if (cyc == m_t + LAT + 1) m_act <= 1'b0;
        end
    end

    int grant_cyc[$];
    bit grant_i[$];
    int low_cyc[$];

    // Per-cycle compare of every DUT output against the model
    always @(negedge clk) begin
        int ph;
        if (!rst) begin
            chk("rst_busy", bus.busy, 0);         chk("rst_i_gnt", bus.i_gnt, 0);
            chk("rst_d_gnt", bus.d_gnt, 0);       chk("rst_i_rvalid", bus.i_rvalid, 0);
            chk("rst_d_rvalid", bus.d_rvalid, 0); chk("rst_i_rdata", bus.i_rdata, 0);
            chk("rst_d_rdata", bus.d_rdata, 0);   chk("rst_mem_en", bus.mem_en, 0);
            chk("rst_mem_we", bus.mem_we, 0);     chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
        end else begin
            ph = cyc - m_t;
            chk("busy", bus.busy, m_act);
            chk("i_gnt", bus.i_gnt, m_act && ph == 0 && !m_d);
            chk("d_gnt", bus.d_gnt, m_act && ph == 0 && m_d);
            chk("mem_en", bus.mem_en, m_act && ph == 0);
            chk("i_rvalid", bus.i_rvalid, m_act && ph == LAT + 1 && !m_d);
            chk("d_rvalid", bus.d_rvalid, m_act && ph == LAT + 1 && m_d);
            chk("i_rdata", bus.i_rdata, m_irdata);
            chk("d_rdata", bus.d_rdata, m_drdata);
            if (m_act) chk("mem_addr", bus.mem_addr, m_addr);
            if (m_act && ph == 0) chk("mem_we", bus.mem_we, m_we);
            if (m_act && ph == 0 && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            if (bus.i_gnt || bus.d_gnt) begin
                grant_cyc.push_back(cyc);
                grant_i.push_back(bus.i_gnt);
            end
            if (!bus.busy) low_cyc.push_back(cyc);
        end
    end

    // Wait for a DUT pulse: 0 i_gnt, 1 d_gnt, 2 i_rvalid, 3 d_rvalid
    task automatic wait_for(input int sel, input int bound, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if ((sel == 0 && bus.i_gnt) || (sel == 1 && bus.d_gnt) ||
                (sel == 2 && bus.i_rvalid) || (sel == 3 && bus.d_rvalid)) begin
                at = cyc;
                break;
            end
        end
        vectors++;
        if (at < 0) begin
            miscompares++;
            $display("FAIL wait_%0d: event not seen within %0d cycles, required within bound", sel, bound);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        int t, at, n;
        logic [9:0] ord, exp_ord;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0;

        repeat (3) @(posedge clk);
        #1 chk("reset_busy_lit", bus.busy, 0);
        chk("reset_mem_addr_lit", bus.mem_addr, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single fetch
        #1 bus.i_req = 1; bus.i_addr = 32'h10;
        wait_for(0, 10, t);
        chk("fetch_mem_en", bus.mem_en, 1);
        chk("fetch_mem_addr", bus.mem_addr, 32'h10);
        chk("fetch_mem_we", bus.mem_we, 0);
        @(posedge clk); #1 bus.i_req = 0; bus.i_addr = 32'h77;
        wait_for(2, 10, at);
        chk("fetch_rvalid_lat", at - t, 3);
        chk("fetch_rdata", bus.i_rdata, 32'h0050_0093);

        // Store
        @(posedge clk); #1 bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        wait_for(1, 10, t);
        chk("store_mem_we", bus.mem_we, 1);
        chk("store_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("store_mem_addr", bus.mem_addr, 32'h100);
        @(posedge clk); #1 bus.d_req = 0; bus.d_we = 0; bus.d_wdata = 32'h1111_2222;
        wait_for(3, 10, at);
        chk("store_rvalid_lat", at - t, 3);
        chk("store_rdata", bus.d_rdata, 0);
        chk("store_i_rvalid", bus.i_rvalid, 0);

        // Simultaneous requests: data first, fetch stays pending
        @(posedge clk); #1 bus.i_req = 1; bus.i_addr = 32'h14; bus.d_req = 1; bus.d_addr = 32'h200;
        wait_for(1, 10, t);
        chk("simul_i_gnt_low", bus.i_gnt, 0);
        @(posedge clk); #1 bus.d_req = 0; bus.d_addr = 32'h999;
        wait_for(3, 10, at);
        chk("simul_d_rvalid_lat", at - t, 3);
        chk("simul_d_rdata", bus.d_rdata, 32'h0000_1234);
        wait_for(0, 10, at);
        chk("simul_fetch_access", at - t, 5);
        @(posedge clk); #1 bus.i_req = 0;
        wait_for(2, 10, at);
        chk("simul_i_rvalid_lat", at - t, 8);
        chk("simul_i_rdata", bus.i_rdata, 32'h00A0_0113);

        // Reset during WAIT abandons the load
        @(posedge clk); #1 bus.d_req = 1; bus.d_addr = 32'h40;
        wait_for(1, 10, t);
        @(posedge clk); #1 bus.d_req = 0;
        #2 rst = 1'b0;
        #1 chk("rstwait_busy", bus.busy, 0);
        chk("rstwait_mem_addr", bus.mem_addr, 0);
        chk("rstwait_d_rdata", bus.d_rdata, 0);
        chk("rstwait_i_rdata", bus.i_rdata, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        n = 0;
        repeat (8) begin @(negedge clk); if (bus.d_rvalid) n++; end
        chk("rstwait_no_rvalid", n, 0);
        chk("rstwait_busy_after", bus.busy, 0);

        // Fetch request held for 20 cycles
        grant_cyc.delete(); grant_i.delete(); low_cyc.delete();
        @(posedge clk); #1 bus.i_req = 1; bus.i_addr = 32'h10;
        repeat (20) @(posedge clk);
        #1 bus.i_req = 0;
        repeat (8) @(posedge clk);
        chk("held_grant_count", grant_cyc.size(), 4);
        for (int k = 1; k < grant_cyc.size(); k++)
            chk("held_grant_gap", grant_cyc[k] - grant_cyc[k-1], 5);
        n = 0;
        if (grant_cyc.size() > 0)
            foreach (low_cyc[k])
                if (low_cyc[k] > grant_cyc[0] && low_cyc[k] < grant_cyc[grant_cyc.size()-1]) n++;
        chk("held_busy_low_cycles", n, 3);

        // Both requests held continuously: grant order
        grant_cyc.delete(); grant_i.delete();
        @(posedge clk); #1 bus.i_req = 1; bus.i_addr = 32'h10; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        n = 0;
        while (grant_cyc.size() < 10 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.i_req = 0; bus.d_req = 0;
        repeat (8) @(posedge clk);
        chk("starve_grant_count", grant_cyc.size(), 10);
        ord = '0;
        for (int k = 0; k < 10 && k < grant_i.size(); k++) ord[k] = grant_i[k];
`ifdef ARB_ANTISTARVE_EN
        exp_ord = 10'b10_0001_0000;
`else
        exp_ord = 10'b00_0000_0000;
`endif
        chk("starve_grant_order", 32'(ord), 32'(exp_ord));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
